// File: rtl/uart_tx_engine.sv
// uart_tx_engine: start/data/parity/stop/gap UART transmitter.
// Parity support is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_engine #(
  parameter int BAUD_DIV  = 434,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int GAP_BITS  = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [1:0]           i_parity_mode,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int CW = $clog2(DATA_BITS + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] GAP    = 3'd5;

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic [3:0]    GAP_LAST  = 4'(GAP_BITS - 1);

  logic [2:0]           state;
  logic [2:0]           state_n;
  logic [BW-1:0]        baud_cnt;
  logic [CW-1:0]        bit_cnt;
  logic [3:0]           gap_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_end;
  logic                 accept;
  logic                 entry;
  logic                 par_on;
  logic                 par_bit;

  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);
  assign accept  = i_valid && o_ready;
  assign bit_end = (baud_cnt == BAUD_LAST);
  assign entry   = (state_n != state);

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;

  // Capture parity mode and the parity of the word at accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (accept) begin
      par_en_q  <= (i_parity_mode == 2'b01) ||
                   (i_parity_mode == 2'b10);
      par_bit_q <= (^i_data) ^ (i_parity_mode == 2'b10);
    end
  end

  assign par_on  = par_en_q;
  assign par_bit = par_bit_q;
`else
  logic unused_par;
  assign unused_par = ^i_parity_mode;
  assign par_on     = 1'b0;
  assign par_bit    = 1'b1;
`endif

  // Next-state sequencing of the frame.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:
        if (i_valid) state_n = START;
      START:
        if (bit_end) state_n = DATA;
      DATA:
        if (bit_end && bit_cnt == DATA_LAST)
          state_n = par_on ? PARITY : STOP;
      PARITY:
        if (!par_on) state_n = IDLE;
        else if (bit_end) state_n = STOP;
      STOP:
        if (bit_end && bit_cnt == STOP_LAST)
          state_n = (GAP_BITS > 0) ? GAP : IDLE;
      GAP:
        if (bit_end && gap_cnt == GAP_LAST)
          state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_n;
  end

  // Baud counter, restarted on entry and at each bit boundary.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      baud_cnt <= '0;
    else if (entry || bit_end || state == IDLE)
      baud_cnt <= '0;
    else
      baud_cnt <= baud_cnt + 1'b1;
  end

  // Bit counter for data and stop bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      bit_cnt <= '0;
    else if (entry)
      bit_cnt <= '0;
    else if (bit_end && (state == DATA || state == STOP))
      bit_cnt <= bit_cnt + 1'b1;
  end

  // Gap bit-time counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      gap_cnt <= '0;
    else if (entry)
      gap_cnt <= '0;
    else if (bit_end && state == GAP)
      gap_cnt <= gap_cnt + 1'b1;
  end

  // Shift register: load at accept, shift right per data bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      shreg <= '0;
    else if (accept)
      shreg <= i_data;
    else if (state == DATA && bit_end)
      shreg <= shreg >> 1;
  end

  // Registered line driver, one cycle behind the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_tx <= 1'b1;
    else begin
      case (state)
        START:   o_tx <= 1'b0;
        DATA:    o_tx <= shreg[0];
        PARITY:  o_tx <= par_bit;
        default: o_tx <= 1'b1;
      endcase
    end
  end

  // Completion pulse on leaving the last stop bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_done <= 1'b0;
    else          o_done <= (state == STOP) && (state_n != STOP);
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed checks of the UART transmitter.
// Covers 8-bit frames, 5N2 with gap, back-to-back and reset.
module tb_uart_tx_engine;

  localparam int BD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] data0;
  logic [1:0] mode0;
  logic       valid0, ready0, tx0, busy0, done0;
  logic [4:0] data1;
  logic [1:0] mode1;
  logic       valid1, ready1, tx1, busy1, done1;

  uart_tx_engine #(
    .BAUD_DIV(BD), .DATA_BITS(8),
    .STOP_BITS(1), .GAP_BITS(0)
  ) u0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_data(data0), .i_valid(valid0),
    .o_ready(ready0), .i_parity_mode(mode0),
    .o_tx(tx0), .o_busy(busy0), .o_done(done0)
  );

  uart_tx_engine #(
    .BAUD_DIV(BD), .DATA_BITS(5),
    .STOP_BITS(2), .GAP_BITS(2)
  ) u1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_data(data1), .i_valid(valid1),
    .o_ready(ready1), .i_parity_mode(mode1),
    .o_tx(tx1), .o_busy(busy1), .o_done(done1)
  );

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  mode;
    int          nb;
    logic [11:0] fr;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Entered at the negedge right after the accept edge.
  task automatic run_u0(input logic [11:0] fr,
                        input int nb,
                        input string nm);
    int bad;
    int f;
    bad = 0;
    f = nb * BD;
    chk({nm, " latency"}, 32'(tx0), 32'd1);
    for (int c = 0; c < f; c++) begin
      @(negedge clk);
      if (tx0 !== fr[c / BD]) bad++;
      if (c == f - 2) begin
        chk({nm, " done early"}, 32'(done0), 32'd0);
        chk({nm, " busy mid"}, 32'(busy0), 32'd1);
      end
      if (c == f - 1) begin
        chk({nm, " done"}, 32'(done0), 32'd1);
        chk({nm, " busy end"}, 32'(busy0), 32'd0);
      end
    end
    chk({nm, " line"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int bad;
    int dn;
    logic [7:0] fr1;
    logic [7:0] fr2;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'h55, 2'b00, 10, 12'h2AA};
    vecs[1] = '{8'h07, 2'b01, 11, 12'h60E};
    vecs[2] = '{8'h07, 2'b10, 11, 12'h40E};
    vecs[3] = '{8'hA5, 2'b01, 11, 12'h54A};
`else
    vecs[0] = '{8'h55, 2'b00, 10, 12'h2AA};
    vecs[1] = '{8'hA5, 2'b01, 10, 12'h34A};
    vecs[2] = '{8'h00, 2'b10, 10, 12'h200};
    vecs[3] = '{8'hFF, 2'b11, 10, 12'h3FE};
`endif

    rst_n = 1'b0;
    data0 = '0; mode0 = '0; valid0 = 1'b0;
    data1 = '0; mode1 = '0; valid1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst tx", 32'(tx0), 32'd1);
    chk("rst busy", 32'(busy0), 32'd0);
    chk("rst done", 32'(done0), 32'd0);
    chk("rst ready", 32'(ready0), 32'd1);
    chk("rst tx1", 32'(tx1), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst ready", 32'(ready0), 32'd1);

    // Reset while data bit 3 of 0x55 is on the line.
    data0 = 8'h55; valid0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid0 = 1'b0;
    for (int c = 0; c < 18; c++) @(negedge clk);
    chk("pre-rst bit3", 32'(tx0), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async tx", 32'(tx0), 32'd1);
    chk("async busy", 32'(busy0), 32'd0);
    chk("async ready", 32'(ready0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done0) dn++;
      if (busy0 || !tx0) bad++;
    end
    chk("no done after rst", 32'(dn), 32'd0);
    chk("idle after rst", 32'(bad), 32'd0);

    // Table-driven frames on the 8-bit engine.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data0 = vecs[i].data;
      mode0 = vecs[i].mode;
      valid0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid0 = 1'b0;
      data0 = ~vecs[i].data;
      mode0 = vecs[i].mode ^ 2'b11;
      run_u0(vecs[i].fr, vecs[i].nb,
             $sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d pulse", i),
          32'(done0), 32'd0);
      repeat (3) @(negedge clk);
    end

    // Back-to-back frames with valid held.
    mode0 = 2'b00;
    data0 = 8'h55; valid0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data0 = 8'hFF;
    run_u0(12'h2AA, 10, "b2b1");
    chk("b2b idle ready", 32'(ready0), 32'd1);
    @(negedge clk);
    chk("b2b accepted", 32'(ready0), 32'd0);
    valid0 = 1'b0;
    run_u0(12'h3FE, 10, "b2b2");

    // 5N2 engine with a two-bit gap, two words queued.
    fr1 = 8'hFE;
    fr2 = 8'hD4;
    @(negedge clk);
    data1 = 5'h1F; mode1 = 2'b00; valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data1 = 5'h0A;
    bad = 0;
    dn = 0;
    for (int c = 0; c < 42; c++) begin
      @(negedge clk);
      if (c < 32 && tx1 !== fr1[c / BD]) bad++;
      if (c >= 32 && c <= 40 && tx1 !== 1'b1) bad++;
      if (c >= 31 && c <= 38 && ready1) dn++;
      if (c == 31) begin
        chk("g done", 32'(done1), 32'd1);
        chk("g busy in gap", 32'(busy1), 32'd1);
      end
      if (c == 32) chk("g pulse", 32'(done1), 32'd0);
      if (c == 39) chk("g ready", 32'(ready1), 32'd1);
      if (c == 40) begin
        chk("g accept", 32'(ready1), 32'd0);
        valid1 = 1'b0;
      end
      if (c == 41) chk("g start2", 32'(tx1), 32'd0);
    end
    chk("g line1", 32'(bad), 32'd0);
    chk("g ready low", 32'(dn), 32'd0);
    bad = 0;
    for (int c = 1; c < 32; c++) begin
      @(negedge clk);
      if (tx1 !== fr2[c / BD]) bad++;
      if (c == 30) chk("g2 early", 32'(done1), 32'd0);
      if (c == 31) chk("g2 done", 32'(done1), 32'd1);
    end
    chk("g line2", 32'(bad), 32'd0);
    repeat (10) @(negedge clk);
    chk("g idle", 32'(busy1), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Parametrised UART transmitter that merges sequencing, baud timing, serialization and inter-frame spacing into one block. Accepts a parallel word through a valid/ready handshake. Emits a configurable asynchronous frame: start bit, 5–9 data bits LSB first, optional parity, 1–2 stop bits, then a programmable idle gap. It sits between the CPU-side UART register interface and the TX pin.

## Interface
- `BAUD_DIV`, default 434: clock cycles per bit-time; must be ≥ 2.
- `DATA_BITS`, default 8: data bits per frame; legal range 5–9.
- `STOP_BITS`, default 1: stop bits per frame; 1 or 2.
- `GAP_BITS`, default 0: idle bit-times inserted after the stop bit(s) before the next accept; legal range 0–15.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_data`  in  DATA_BITS  word to transmit.
- `i_valid`  in  1  `i_data` is valid.
- `o_ready`  out  1  engine can accept a word.
- `i_parity_mode`  in  2  00 none, 01 even, 10 odd, 11 none.
- `o_tx`  out  1  serial line; registered; idles high.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse at frame completion.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, GAP.
- Accept: occurs on a rising edge with `i_valid && o_ready`.
  - `o_ready` = (state == IDLE), combinational.
  - At accept, `i_data` is latched into the shift register and `i_parity_mode` is latched; parity is computed from the latched data.
  - Input changes after accept have no effect on the frame.
- Line level per state:
  - IDLE → 1.
  - START → 0.
  - DATA → shift-register LSB; the register shifts right at the end of each bit-time.
  - PARITY → XOR of the data bits for even mode; inverted XOR for odd mode.
  - STOP → 1.
  - GAP → 1.
- Baud counter:
  - Width `$clog2(BAUD_DIV)`.
  - Cleared on every state entry; counts 0..BAUD_DIV-1.
  - A bit-time ends when the counter reaches BAUD_DIV-1.
- Bit counter:
  - Width `$clog2(DATA_BITS+1)`.
  - Counts data bits in DATA and stop bits in STOP; cleared on entry to each.
- Transitions:
  - IDLE → START on accept.
  - START → DATA after 1 bit-time.
  - DATA → PARITY after DATA_BITS bit-times if parity is active; otherwise DATA → STOP.
  - PARITY → STOP after 1 bit-time.
  - STOP → GAP after STOP_BITS bit-times if GAP_BITS > 0; otherwise STOP → IDLE.
  - GAP → IDLE after GAP_BITS bit-times.
  - Undefined state encodings → IDLE.
- `o_done` is high for the single cycle following the last stop-bit cycle, i.e. the first cycle of GAP or IDLE.
- Reset values: state IDLE, `o_tx`=1, `o_busy`=0, `o_done`=0, `o_ready`=1, counters 0.
- Reset mid-frame: `o_tx` returns to 1 asynchronously, the frame is abandoned, and no `o_done` is produced.

## Timing
- Accept at edge N → `o_tx` falls at edge N+1 (one cycle registered latency).
- Every bit occupies exactly BAUD_DIV cycles on `o_tx`.
- Frame length = (1 + DATA_BITS + P + STOP_BITS) × BAUD_DIV cycles, where P = 1 with parity and 0 without.
- Next accept is possible no earlier than GAP_BITS × BAUD_DIV cycles after `o_done` (immediately when GAP_BITS = 0).
- With `i_valid` held high continuously and GAP_BITS = 0, frames are back-to-back, separated by exactly one IDLE cycle.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state and parity logic are compiled in, and `i_parity_mode` applies as specified above.
- Not defined: parity logic is removed, `i_parity_mode` is ignored, and every frame is sent with no parity bit.

## Test plan
- 8N1, BAUD_DIV=4, send 0x55 → `o_tx` = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; `o_done` pulses 40 cycles after the start edge.
- Even parity (macro defined), send 0x07 → parity bit 1; odd parity, send 0x07 → parity bit 0; frame length 44 cycles.
- DATA_BITS=5, STOP_BITS=2, send 0x1F → start bit, 11111, then high for 8 cycles; `o_busy` drops at the `o_done` edge.
- GAP_BITS=2, `i_valid` held with two words → second start bit begins 8 cycles after `o_done`, plus 1 accept cycle; `o_ready` stays low throughout the gap.
- Assert reset during DATA bit 3 → `o_tx`=1 asynchronously, `o_busy`=0, no `o_done`; a new frame after reset transmits correctly.
- Macro undefined, `i_parity_mode`=01, send 0xA5 → 40-cycle frame with no parity bit.
